// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer and the extender that consumes its words.
// Holds the eop encodings, FSM state encodings and a reference extend helper.
package imm_pack_pkg;

  localparam int VAL_W = 32;
  localparam int IMM_W = 16;

  typedef enum logic [1:0] {
    EOP_SEXT   = 2'b00,
    EOP_ZEXT   = 2'b01,
    EOP_LUI    = 2'b10,
    EOP_SEXT_W = 2'b11
  } eop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    HI   = 2'b10,
    LO   = 2'b11
  } state_e;

  // Extender behaviour; two-word constants are the OR of both expansions.
  function automatic logic [VAL_W-1:0] eop_extend(input logic [IMM_W-1:0] imm,
                                                  input eop_e eop);
    logic [VAL_W-1:0] r;
    case (eop)
      EOP_SEXT:   r = {{16{imm[15]}}, imm};
      EOP_ZEXT:   r = {16'h0000, imm};
      EOP_LUI:    r = {imm, 16'h0000};
      default:    r = {{16{imm[15]}}, imm[15:2], 2'b00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Input/output stream bundle of the immediate packer.
// Both streams use valid/ready: a word moves on a rising edge where valid and ready are both high;
// the producer holds valid and data stable until that edge, ready may change freely.
interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_imm, out_eop, out_last
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_imm, out_eop, out_last
  );
endinterface

// File: rtl/imm_classify.sv
// Picks the cheapest extender encoding for a 32-bit constant (combinational).
// The zero-extend single-word candidate exists only when IMM_PACK_ZEXT_EN is defined.
module imm_classify
  import imm_pack_pkg::*;
(
  input  logic [VAL_W-1:0] value,
  output logic             split,
  output logic [IMM_W-1:0] imm,
  output eop_e             eop
);

  logic fits_sext;
  logic fits_zext;
  logic fits_lui;

  assign fits_sext = (&value[31:15]) | ~(|value[31:15]);
`ifdef IMM_PACK_ZEXT_EN
  assign fits_zext = ~(|value[31:16]);
`else
  assign fits_zext = 1'b0;
`endif
  assign fits_lui  = ~(|value[15:0]);

  // EOP_SEXT_W is never chosen: anything it covers already fits EOP_SEXT.
  always_comb begin
    split = 1'b0;
    imm   = value[15:0];
    eop   = EOP_SEXT;
    if (fits_sext) begin
      eop = EOP_SEXT;
    end else if (fits_zext) begin
      eop = EOP_ZEXT;
    end else if (fits_lui) begin
      imm = value[31:16];
      eop = EOP_LUI;
    end else begin
      split = 1'b1;
      imm   = value[31:16];
      eop   = EOP_LUI;
    end
  end

endmodule

// File: rtl/imm_pack.sv
// Immediate packer: turns each accepted constant into one or two registered (imm, eop) words.
// Build option IMM_PACK_ZEXT_EN enables the zero-extend single-word encoding.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  imm_pack_if.slave  bus,
  output state_e     dbg_state
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  eop_e             eop_q, eop_d;
  logic             last_q, last_d;
  logic [IMM_W-1:0] lo_q, lo_d;

  logic             cls_split;
  logic [IMM_W-1:0] cls_imm;
  eop_e             cls_eop;
  logic             in_ready;
  logic             accept;

  imm_classify u_classify (
    .value (bus.in_value),
    .split (cls_split),
    .imm   (cls_imm),
    .eop   (cls_eop)
  );

  // A new constant may enter only when the held word is the last one and is leaving.
  assign in_ready = ~reset & ((state_q == IDLE) |
                              (((state_q == ONE) | (state_q == LO)) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    imm_d   = imm_q;
    eop_d   = eop_q;
    last_d  = last_q;
    lo_d    = lo_q;
    case (state_q)
      HI: begin
        if (bus.out_ready) begin
          state_d = LO;
          imm_d   = lo_q;
          eop_d   = EOP_ZEXT;
          last_d  = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          state_d = cls_split ? HI : ONE;
          valid_d = 1'b1;
          imm_d   = cls_imm;
          eop_d   = cls_eop;
          last_d  = ~cls_split;
          lo_d    = bus.in_value[15:0];
        end else if ((state_q != IDLE) && bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      imm_q   <= '0;
      eop_q   <= EOP_SEXT;
      last_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      imm_q   <= imm_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_imm   = imm_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_last  = last_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed vector table, hand-written multi-cycle sequences,
// then random traffic scored against a rule-level model of the encoding.
module tb_imm_pack;
  import imm_pack_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  imm_pack_if bus ();

  imm_pack dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checks ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // word = {imm[15:0], eop[1:0], last}
  function automatic logic [18:0] mk(input logic [15:0] imm, input logic [1:0] eop,
                                     input logic last);
    return {imm, eop, last};
  endfunction

  function automatic logic [18:0] cur_word();
    return {bus.out_imm, bus.out_eop, bus.out_last};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] val, input logic ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_value  = val;
    bus.out_ready = ordy;
  endtask

  task automatic expect_word(input string name, input logic [18:0] w);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_word"}, {13'd0, cur_word()}, {13'd0, w});
  endtask

  task automatic expect_empty(input string name);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [18:0] exp_q[$];
  logic        sb_en = 1'b0;
  logic        hold_prev = 1'b0;
  logic [18:0] prev_word;

  // Encoding rules applied directly to the integer value.
  task automatic model_push(input logic [31:0] v);
    int sv;
    sv = $signed(v);
    if (sv >= -32768 && sv <= 32767)
      exp_q.push_back(mk(v[15:0], 2'b00, 1'b1));
`ifdef IMM_PACK_ZEXT_EN
    else if (v <= 32'h0000_FFFF)
      exp_q.push_back(mk(v[15:0], 2'b01, 1'b1));
`endif
    else if ((v % 32'd65536) == 32'd0)
      exp_q.push_back(mk(16'(v / 32'd65536), 2'b10, 1'b1));
    else begin
      exp_q.push_back(mk(16'(v / 32'd65536), 2'b10, 1'b0));
      exp_q.push_back(mk(16'(v % 32'd65536), 2'b01, 1'b1));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else if (sb_en) begin
      if (hold_prev) begin
        check("sb_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("sb_hold_word", {13'd0, cur_word()}, {13'd0, prev_word});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got word 0x%05h expected none", cur_word());
        end else begin
          check("sb_word", {13'd0, cur_word()}, {13'd0, exp_q.pop_front()});
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_word = cur_word();
      if (bus.in_valid && bus.in_ready) model_push(bus.in_value);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] edge_vals [6] = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000,
                                 32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_7FFF};

  function automatic logic [31:0] gen_value();
    logic [15:0] r;
    logic [31:0] v;
    r = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 4))
      0:       v = {{16{r[15]}}, r};
      1:       v = {r, 16'h0000};
      2:       v = {16'h0000, r};
      3:       v = $urandom;
      default: v = edge_vals[$urandom_range(0, 5)];
    endcase
    return v;
  endfunction

  typedef struct {
    logic [31:0] value;
    int          n_words;
    logic [18:0] w0;
    logic [18:0] w1;
  } vec_t;

  vec_t tbl[$];

  // ---------------- test sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;

    // Reset behaviour
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_word", {13'd0, cur_word()}, 32'd0);
    check("post_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Directed vector table
    tbl.push_back('{32'hFFFF_FFFC, 1, mk(16'hFFFC, 2'b00, 1'b1), 19'd0});
    tbl.push_back('{32'h1234_0000, 1, mk(16'h1234, 2'b10, 1'b1), 19'd0});
`ifdef IMM_PACK_ZEXT_EN
    tbl.push_back('{32'h0000_8000, 1, mk(16'h8000, 2'b01, 1'b1), 19'd0});
    tbl.push_back('{32'h0000_FFFF, 1, mk(16'hFFFF, 2'b01, 1'b1), 19'd0});
`else
    tbl.push_back('{32'h0000_8000, 2, mk(16'h0000, 2'b10, 1'b0), mk(16'h8000, 2'b01, 1'b1)});
    tbl.push_back('{32'h0000_FFFF, 2, mk(16'h0000, 2'b10, 1'b0), mk(16'hFFFF, 2'b01, 1'b1)});
`endif
    tbl.push_back('{32'h0000_0005, 1, mk(16'h0005, 2'b00, 1'b1), 19'd0});
    tbl.push_back('{32'h0000_7FFF, 1, mk(16'h7FFF, 2'b00, 1'b1), 19'd0});
    tbl.push_back('{32'hFFFF_8000, 1, mk(16'h8000, 2'b00, 1'b1), 19'd0});
    tbl.push_back('{32'hFFFF_0000, 1, mk(16'hFFFF, 2'b10, 1'b1), 19'd0});
    tbl.push_back('{32'h0001_0000, 1, mk(16'h0001, 2'b10, 1'b1), 19'd0});
    tbl.push_back('{32'h0000_0000, 1, mk(16'h0000, 2'b00, 1'b1), 19'd0});
    tbl.push_back('{32'h1234_5678, 2, mk(16'h1234, 2'b10, 1'b0), mk(16'h5678, 2'b01, 1'b1)});
    tbl.push_back('{32'h8000_0001, 2, mk(16'h8000, 2'b10, 1'b0), mk(16'h0001, 2'b01, 1'b1)});

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].value, 1'b1);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check($sformatf("tbl%0d_w0_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("tbl%0d_w0", i), {13'd0, cur_word()}, {13'd0, tbl[i].w0});
      if (tbl[i].n_words == 2) begin
        @(negedge clk);
        check($sformatf("tbl%0d_w1_valid", i), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("tbl%0d_w1", i), {13'd0, cur_word()}, {13'd0, tbl[i].w1});
      end
      expect_empty($sformatf("tbl%0d_idle", i));
    end

    // Split under back-pressure; a second constant waits on in_valid
    drive(1'b1, 32'h1234_5678, 1'b0);
    drive(1'b1, 32'h0000_0005, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_word", {13'd0, cur_word()}, {13'd0, mk(16'h1234, 2'b10, 1'b0)});
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_state", {30'd0, dbg_state}, {30'd0, HI});
      if (k < 2) drive(1'b1, 32'h0000_0005, 1'b0);
    end
    drive(1'b1, 32'h0000_0005, 1'b1);
    @(negedge clk);
    check("stall_rel_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("stall_rel_word", {13'd0, cur_word()}, {13'd0, mk(16'h1234, 2'b10, 1'b0)});
    @(negedge clk);
    check("stall_lo_word", {13'd0, cur_word()}, {13'd0, mk(16'h5678, 2'b01, 1'b1)});
    check("stall_lo_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    expect_word("stall_next", mk(16'h0005, 2'b00, 1'b1));
    expect_empty("stall_idle");

    // Back-to-back single-word constants
    drive(1'b1, 32'h0000_0005, 1'b1);
    @(negedge clk);
    check("b2b_in_ready0", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'h0000_7FFF, 1'b1);
    expect_word("b2b_w0", mk(16'h0005, 2'b00, 1'b1));
    check("b2b_in_ready1", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'hFFFF_8000, 1'b1);
    expect_word("b2b_w1", mk(16'h7FFF, 2'b00, 1'b1));
    check("b2b_in_ready2", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    expect_word("b2b_w2", mk(16'h8000, 2'b00, 1'b1));
    expect_empty("b2b_idle");

    // Reset while holding split word 1
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("rsplit_hi_word", {13'd0, cur_word()}, {13'd0, mk(16'hDEAD, 2'b10, 1'b0)});
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rsplit_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rsplit_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rsplit_word", {13'd0, cur_word()}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rsplit_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    drive(1'b1, 32'h1234_0000, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("rsplit_next_word", {13'd0, cur_word()}, {13'd0, mk(16'h1234, 2'b10, 1'b1)});
    check("rsplit_next_valid", {31'd0, bus.out_valid}, 32'd1);
    expect_empty("rsplit_idle");

    // Random traffic against the model
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++)
      drive($urandom_range(0, 99) < 60, gen_value(), $urandom_range(0, 99) < 70);
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("sb_drain_left", exp_q.size(), 32'd0);
    check("sb_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: in_value is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts in_value this cycle.
REQ-005 SHALL have port in_value, input, 32 bits: constant to be materialised.
REQ-006 SHALL have port out_valid, output, 1 bit: out_imm/out_eop/out_last are valid.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes the current output word.
REQ-008 SHALL have port out_imm, output, 16 bits: immediate field for the extender.
REQ-009 SHALL have port out_eop, output, 2 bits: extender opcode (00 sign, 01 zero, 10 upper-half, 11 sign word-aligned).
REQ-010 SHALL have port out_last, output, 1 bit: final word for the current constant.

Function
REQ-011 SHALL encode each accepted 32-bit constant as one or two (imm, eop) words that reproduce it through the extender (OR-combined when two).
REQ-012 SHALL select, in priority order: eop 00 when in_value[31:15] is all 0s or all 1s (imm = in_value[15:0]); eop 01 when in_value[31:16] == 0; eop 10 when in_value[15:0] == 0 (imm = in_value[31:16]); otherwise split.
REQ-013 SHALL never emit eop 11, because any eop 11 value is also eop 00 representable.
REQ-014 SHALL emit a split as word 1 {imm = in_value[31:16], eop 10, last 0}, then word 2 {imm = in_value[15:0], eop 01, last 1}.
REQ-015 SHALL use states IDLE (nothing held), ONE (single word held), HI (split word 1 held) and LO (split word 2 held).
REQ-016 SHALL assert in_ready = IDLE, or (ONE or LO) and out_ready.
REQ-017 SHALL register an accepted constant, so out_valid rises the cycle after acceptance (latency 1), giving one single-word constant per cycle under continuous out_ready.
REQ-018 SHALL hold out_valid, out_imm, out_eop and out_last stable while out_valid is high and out_ready is low.
REQ-019 SHALL make transitions: HI with out_ready -> LO; ONE or LO with out_ready and no accept -> IDLE; ONE or LO with out_ready and an accept -> ONE or HI per the new constant.
REQ-020 SHALL treat in_valid while in_ready is low as not accepted, with no state change.
REQ-021 SHALL ignore out_ready while out_valid is low.

Reset
REQ-022 SHALL, while reset is high, go to IDLE and drive out_valid=0, out_imm=0, out_eop=00, out_last=0; in_ready SHALL be 0 during reset and 1 in the first cycle after it.
REQ-023 SHALL, on reset mid-split (HI or LO), drop any pending word 2 and emit no partial output afterwards.

Configuration
REQ-024 SHALL compile in the eop 01 single-word candidate when macro IMM_PACK_ZEXT_EN is defined.
REQ-025 SHALL, when IMM_PACK_ZEXT_EN is undefined, skip the eop 01 single-word candidate, so values such as 0x0000_8000 split into {0x0000, 10} then {0x8000, 01}; split word 2 still uses eop 01.

Structure
REQ-026 SHALL take the eop encodings (EOP_SEXT, EOP_ZEXT, EOP_LUI, EOP_SEXT_W) and state encodings from a shared package that the extender also uses.
REQ-027 SHALL place the candidate-selection logic in a combinational sub-module imm_classify (in_value -> single/split flag, imm, eop); imm_pack owns only the FSM and output registers.

Verification
REQ-028 SHALL cover: in_value 0xFFFF_FFFC with out_ready=1 -> one word {0xFFFC, 00, last 1} the cycle after acceptance.
REQ-029 SHALL cover: 0x1234_0000 -> {0x1234, 10, last 1}; and 0x0000_8000 -> {0x8000, 01, last 1} with the macro, a two-word split without it.
REQ-030 SHALL cover: 0x1234_5678 with out_ready low 3 cycles -> {0x1234, 10, 0} held stable; in_ready low throughout; then {0x5678, 01, 1}.
REQ-031 SHALL cover: back-to-back constants 0x5, 0x7FFF, 0xFFFF_8000 with out_ready=1 -> three single words on three consecutive cycles, in_ready constantly high.
REQ-032 SHALL cover: reset asserted while in HI for 0xDEAD_BEEF -> out_valid 0 the next cycle, no 0xBEEF word ever emitted; next input processed normally.
